// File: rtl/layer_compositor.sv
// Layer compositor: resolves prioritised layer hits into one registered VGA colour,
// with per-layer blinking, a frame-counted full-screen flash and sync alignment.
module layer_compositor #(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 12,
    parameter int BLINK_FRAMES = 16,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pixel_en,
    input  logic                          video_on,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         blink_mask,
    input  logic [COLOR_W-1:0]            bg_color,
    input  logic                          flash_req,
    input  logic [COLOR_W-1:0]            flash_color,
    output logic [COLOR_W-1:0]            vga,
    output logic                          VGA_HS,
    output logic                          VGA_VS,
    output logic                          flash_busy
);

    localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int BW = $clog2(BLINK_FRAMES);
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    typedef enum logic {
        IDLE,
        FLASH
    } state_t;

    state_t state, state_next;

    logic [FW-1:0] flash_cnt, flash_cnt_next;
    logic          flash_phase, flash_phase_next;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [NUM_LAYERS-1:0] eff_on;
    logic [COLOR_W-1:0]    colors [NUM_LAYERS];
    logic [IW-1:0]         sel;
    logic                  hit;
    logic [COLOR_W-1:0]    pick;

    logic [COLOR_W-1:0] s1_color;
    logic               s1_video;
    logic               s1_hs;
    logic               s1_vs;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_col
        assign colors[g] = layer_color[g*COLOR_W +: COLOR_W];
    end

    assign eff_on = layer_on & ~(blink_mask & {NUM_LAYERS{blink_phase}});

    // Scan from the lowest priority upward so the lowest hit index wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_on[i]) begin
                hit = 1'b1;
                sel = IW'(i);
            end
        end
    end

    assign pick = hit ? colors[sel] : bg_color;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_color <= '0;
            s1_video <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            vga      <= '0;
            VGA_HS   <= 1'b1;
            VGA_VS   <= 1'b1;
        end else if (pixel_en) begin
            s1_color <= pick;
            s1_video <= video_on;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            if (!s1_video) begin
                vga <= '0;
            end else if (flash_phase) begin
                vga <= flash_color;
            end else begin
                vga <= s1_color;
            end
            VGA_HS <= s1_hs;
            VGA_VS <= s1_vs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else begin
            state       <= state_next;
            flash_cnt   <= flash_cnt_next;
            flash_phase <= flash_phase_next;
        end
    end

    // A frame_start coinciding with entry is not counted; requests in FLASH are dropped.
    always_comb begin
        state_next       = state;
        flash_cnt_next   = flash_cnt;
        flash_phase_next = flash_phase;
        unique case (state)
            IDLE: begin
                if (flash_req) begin
                    state_next       = FLASH;
                    flash_cnt_next   = '0;
                    flash_phase_next = 1'b1;
                end
            end
            FLASH: begin
                if (frame_start) begin
                    if (flash_cnt == FLASH_LAST) begin
                        state_next       = IDLE;
                        flash_cnt_next   = '0;
                        flash_phase_next = 1'b0;
                    end else begin
                        flash_cnt_next   = flash_cnt + FW'(1);
                        flash_phase_next = ~flash_phase;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign flash_busy = (state == FLASH);

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: scoreboard of expected pixels, popped two
// strobes after they are driven; blink/flash state tracked from frame counts.
module tb_layer_compositor;

    localparam int NL  = 4;
    localparam int CW  = 12;
    localparam int BLK = 2;
    localparam int FLS = 3;

    typedef struct packed {
        logic [CW-1:0] color;
        logic          video;
        logic          hs;
        logic          vs;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pixel_en;
    logic             video_on;
    logic             hsync_in;
    logic             vsync_in;
    logic             frame_start;
    logic [NL-1:0]    layer_on;
    logic [NL*CW-1:0] layer_color;
    logic [NL-1:0]    blink_mask;
    logic [CW-1:0]    bg_color;
    logic             flash_req;
    logic [CW-1:0]    flash_color;
    logic [CW-1:0]    vga;
    logic             VGA_HS;
    logic             VGA_VS;
    logic             flash_busy;

    layer_compositor #(
        .NUM_LAYERS(NL),
        .COLOR_W(CW),
        .BLINK_FRAMES(BLK),
        .FLASH_FRAMES(FLS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pixel_en(pixel_en),
        .video_on(video_on),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .frame_start(frame_start),
        .layer_on(layer_on),
        .layer_color(layer_color),
        .blink_mask(blink_mask),
        .bg_color(bg_color),
        .flash_req(flash_req),
        .flash_color(flash_color),
        .vga(vga),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .flash_busy(flash_busy)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] pal [NL];
    exp_t          sb [$];
    int            vectors = 0;
    int            errors  = 0;
    int            frames  = 0;
    int            m_fidx  = 0;
    logic          m_busy  = 1'b0;
    logic          m_blink = 1'b0;
    logic          m_flash = 1'b0;
    logic [CW-1:0] last_vga;
    logic          last_hs;
    logic          last_vs;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] ref_color(input logic [NL-1:0] on);
        logic [CW-1:0] c;
        c = bg_color;
        for (int i = 0; i < NL; i++) begin
            if (on[i] && !(blink_mask[i] && m_blink)) begin
                c = pal[i];
                break;
            end
        end
        return c;
    endfunction

    task automatic pix(input logic v, input logic [NL-1:0] on, input logic hs, input logic vs);
        exp_t e;
        logic [CW-1:0] ev;
        video_on = v;
        layer_on = on;
        hsync_in = hs;
        vsync_in = vs;
        pixel_en = 1'b1;
        sb.push_back('{color: ref_color(on), video: v, hs: hs, vs: vs});
        tick();
        pixel_en = 1'b0;
        e  = sb.pop_front();
        ev = !e.video ? '0 : (m_flash ? flash_color : e.color);
        chk("vga", vga, ev);
        chk("VGA_HS", {11'b0, VGA_HS}, {11'b0, e.hs});
        chk("VGA_VS", {11'b0, VGA_VS}, {11'b0, e.vs});
        last_vga = ev;
        last_hs  = e.hs;
        last_vs  = e.vs;
    endtask

    task automatic hold(input int n);
        video_on = ~video_on;
        layer_on = ~layer_on;
        hsync_in = ~hsync_in;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("hold_vga", vga, last_vga);
            chk("hold_hs", {11'b0, VGA_HS}, {11'b0, last_hs});
        end
    endtask

    task automatic advance_flash();
        if (m_busy) begin
            m_fidx++;
            if (m_fidx == FLS) m_busy = 1'b0;
        end
        m_flash = m_busy && (m_fidx % 2 == 0);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        frames++;
        m_blink = ((frames / BLK) % 2) == 1;
        advance_flash();
        chk("busy_frame", {11'b0, flash_busy}, {11'b0, m_busy});
    endtask

    task automatic req(input logic with_frame);
        flash_req   = 1'b1;
        frame_start = with_frame;
        tick();
        flash_req   = 1'b0;
        frame_start = 1'b0;
        if (with_frame) begin
            frames++;
            m_blink = ((frames / BLK) % 2) == 1;
        end
        if (m_busy) begin
            if (with_frame) advance_flash();
        end else begin
            m_busy  = 1'b1;
            m_fidx  = 0;
            m_flash = 1'b1;
        end
        chk("busy_req", {11'b0, flash_busy}, {11'b0, m_busy});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_vga", vga, '0);
        chk("rst_hs", {11'b0, VGA_HS}, 12'd1);
        chk("rst_vs", {11'b0, VGA_VS}, 12'd1);
        chk("rst_busy", {11'b0, flash_busy}, 12'd0);
        rst     = 1'b0;
        frames  = 0;
        m_fidx  = 0;
        m_busy  = 1'b0;
        m_blink = 1'b0;
        m_flash = 1'b0;
        sb.delete();
        sb.push_back('{color: '0, video: 1'b0, hs: 1'b1, vs: 1'b1});
    endtask

    initial begin
        pal[0] = 12'h00F;
        pal[1] = 12'hF00;
        pal[2] = 12'h0F0;
        pal[3] = 12'h0FF;
        rst         = 1'b1;
        pixel_en    = 1'b0;
        video_on    = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        frame_start = 1'b0;
        layer_on    = '0;
        layer_color = {pal[3], pal[2], pal[1], pal[0]};
        blink_mask  = '0;
        bg_color    = 12'h0F0;
        flash_req   = 1'b0;
        flash_color = 12'hFFF;
        tick();
        do_reset();

        // priority
        pix(1, 4'b0110, 1, 1);
        pix(1, 4'b0000, 1, 1);
        pix(1, 4'b1000, 1, 1);
        pix(1, 4'b1111, 1, 1);
        pix(1, 4'b1100, 1, 1);
        pix(1, 4'b0110, 1, 1);

        // blanking and sync alignment
        pix(0, 4'b1111, 1, 1);
        pix(1, 4'b0001, 0, 1);
        pix(1, 4'b0010, 1, 0);
        pix(1, 4'b0100, 1, 1);

        // sparse strobes
        for (int k = 0; k < 6; k++) begin
            pix(k % 3 != 0, 4'(k * 5), k % 2 == 1, 1);
            hold(3);
        end

        // blink
        do_reset();
        blink_mask = 4'b0001;
        for (int f = 0; f < 6; f++) begin
            pix(1, 4'b0011, 1, 1);
            pix(1, 4'b0011, 1, 1);
            frame();
        end
        pix(1, 4'b0011, 1, 1);

        // flash sequence with an ignored mid-sequence request
        do_reset();
        blink_mask = '0;
        pix(1, 4'b0010, 1, 1);
        req(0);
        pix(1, 4'b0010, 1, 1);
        pix(0, 4'b0010, 1, 1);
        pix(1, 4'b0100, 1, 1);
        frame();
        pix(1, 4'b0010, 1, 1);
        pix(1, 4'b0010, 1, 1);
        req(0);
        pix(1, 4'b1000, 1, 1);
        frame();
        pix(1, 4'b0010, 1, 1);
        pix(0, 4'b0010, 1, 1);
        frame();
        pix(1, 4'b0010, 1, 1);
        pix(1, 4'b0001, 1, 1);

        // request coinciding with frame_start in IDLE
        req(1);
        pix(1, 4'b0010, 1, 1);
        pix(1, 4'b0010, 1, 1);
        frame();
        frame();
        pix(1, 4'b0100, 1, 1);
        pix(1, 4'b0100, 1, 1);
        frame();
        pix(1, 4'b0100, 1, 1);
        pix(1, 4'b0100, 1, 1);

        // reset during flash with blink_phase set
        do_reset();
        blink_mask = 4'b0001;
        frame();
        frame();
        req(0);
        pix(1, 4'b0011, 0, 0);
        pix(1, 4'b0011, 0, 0);
        do_reset();
        pix(1, 4'b0011, 1, 1);
        pix(1, 4'b0011, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
